// File: rtl/reset_seq_pkg.sv
// rtl/reset_seq_pkg.sv - shared types and helpers for the reset domain sequencer
package reset_seq_pkg;

  typedef enum logic [2:0] {
    IDLE,
    HOLD,
    GAP,
    NEXT,
    FIN
  } seq_state_e;

  localparam logic OP_RELEASE = 1'b0;
  localparam logic OP_ASSERT  = 1'b1;

  localparam int MAX_DOMAINS = 16;

  // Callers zero-extend their mask to MAX_DOMAINS and truncate the result.
  function automatic logic [MAX_DOMAINS-1:0] lsb_onehot(input logic [MAX_DOMAINS-1:0] m);
    return m & (~m + MAX_DOMAINS'(1));
  endfunction

  function automatic logic [3:0] lsb_index(input logic [MAX_DOMAINS-1:0] m);
    logic [3:0] idx;
    idx = '0;
    for (int i = MAX_DOMAINS - 1; i >= 0; i--) begin
      if (m[i]) idx = 4'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/seq_down_counter.sv
// rtl/seq_down_counter.sv - loadable down counter with terminal-count flag at 1
module seq_down_counter #(
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_load,
  input  logic [CNT_W-1:0] i_load_value,
  input  logic             i_en,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_count;

  // Saturates at zero so a stray enable can never wrap to the maximum.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= i_load_value;
    end else if (i_en && (r_count != '0)) begin
      r_count <= r_count - CNT_W'(1);
    end
  end

  assign o_tc = (r_count == CNT_W'(1));

endmodule

// File: rtl/reset_domain_sequencer.sv
// rtl/reset_domain_sequencer.sv - masked assert/hold and ordered, gapped release of per-domain resets
module reset_domain_sequencer
  import reset_seq_pkg::*;
#(
  parameter int N_DOMAINS    = 4,
  parameter int CNT_W        = 8,
  parameter int HOLD_DEFAULT = 16,
  parameter int GAP_DEFAULT  = 4
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_assert,
  input  logic [N_DOMAINS-1:0] req_mask,
  input  logic [CNT_W-1:0]     cfg_hold,
  input  logic [CNT_W-1:0]     cfg_gap,
  output logic [N_DOMAINS-1:0] domain_reset,
  output logic                 busy,
  output logic                 done
);

  seq_state_e           r_state;
  seq_state_e           w_next_state;
  logic [N_DOMAINS-1:0] r_domain_reset;
  logic [N_DOMAINS-1:0] r_remaining;
  logic [CNT_W-1:0]     r_gap;
  logic                 r_done;

  logic                 w_accept;
  logic                 w_do_assert;
  logic                 w_do_release;
  logic                 w_cnt_load;
  logic                 w_cnt_en;
  logic                 w_cnt_tc;
  logic [CNT_W-1:0]     w_cnt_load_value;
  logic [CNT_W-1:0]     w_hold_eff;
  logic [CNT_W-1:0]     w_gap_eff;
  logic [N_DOMAINS-1:0] w_release_src;
  logic [N_DOMAINS-1:0] w_release_oh;

  assign w_hold_eff = (cfg_hold == '0) ? CNT_W'(HOLD_DEFAULT) : cfg_hold;
  assign w_gap_eff  = (cfg_gap == '0) ? CNT_W'(GAP_DEFAULT) : cfg_gap;

  assign req_ready    = (r_state == IDLE) && !r_done;
  assign busy         = (r_state != IDLE);
  assign done         = r_done;
  assign domain_reset = r_domain_reset;
  assign w_accept     = req_valid && req_ready;

  // A release is applied on the edge that enters NEXT, so NEXT is the cycle it becomes visible.
  assign w_release_src    = (r_state == IDLE) ? req_mask : r_remaining;
  assign w_release_oh     = N_DOMAINS'(lsb_onehot(MAX_DOMAINS'(w_release_src)));
  assign w_cnt_load_value = (r_state == IDLE) ? w_hold_eff : r_gap;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    w_do_assert  = 1'b0;
    w_do_release = 1'b0;
    w_cnt_load   = 1'b0;
    w_cnt_en     = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          if (req_mask == '0) begin
            w_next_state = FIN;
          end else if (req_assert == OP_ASSERT) begin
            w_next_state = HOLD;
            w_do_assert  = 1'b1;
            w_cnt_load   = 1'b1;
          end else begin
            w_next_state = NEXT;
            w_do_release = 1'b1;
          end
        end
      end
      HOLD: begin
        if (w_cnt_tc) w_next_state = FIN;
        else          w_cnt_en     = 1'b1;
      end
      NEXT: begin
        if (r_remaining != '0) begin
          w_next_state = GAP;
          w_cnt_load   = 1'b1;
        end else begin
          w_next_state = FIN;
        end
      end
      GAP: begin
        if (w_cnt_tc) begin
          w_next_state = NEXT;
          w_do_release = 1'b1;
        end else begin
          w_cnt_en = 1'b1;
        end
      end
      FIN:     w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_domain_reset <= '1;
      r_remaining    <= '0;
      r_gap          <= '0;
      r_done         <= 1'b0;
    end else begin
      r_done <= (w_next_state == FIN);
      if (w_accept) r_gap <= w_gap_eff;
      if (w_do_assert) r_domain_reset <= r_domain_reset | req_mask;
      if (w_do_release) begin
        r_domain_reset <= r_domain_reset & ~w_release_oh;
        r_remaining    <= w_release_src & ~w_release_oh;
      end
    end
  end

  seq_down_counter #(
    .CNT_W(CNT_W)
  ) u_cnt (
    .i_clk       (clock),
    .i_rst       (reset),
    .i_load      (w_cnt_load),
    .i_load_value(w_cnt_load_value),
    .i_en        (w_cnt_en),
    .o_tc        (w_cnt_tc)
  );

endmodule

// File: tb/tb_reset_domain_sequencer.sv
// tb/tb_reset_domain_sequencer.sv - randomized bench against a timeline model of the sequencer
module tb_reset_domain_sequencer;

  localparam int N = 4;

  logic         clock = 1'b0;
  logic         reset = 1'b1;
  logic         req_valid = 1'b0;
  logic         req_assert = 1'b0;
  logic [N-1:0] req_mask = '0;
  logic [7:0]   cfg_hold = '0;
  logic [7:0]   cfg_gap = '0;
  logic         req_ready;
  logic         busy;
  logic         done;
  logic [N-1:0] domain_reset;

  int checks = 0;
  int errors = 0;
  int e = 0;

  // Last accepted command, expressed as its start edge and effective timing.
  bit           m_have = 1'b0;
  int           m_t = 0;
  int           m_h = 0;
  int           m_g = 0;
  bit           m_op = 1'b0;
  logic [N-1:0] m_mask = '0;
  logic [N-1:0] m_base = '1;

  always #5 clock = ~clock;

  reset_domain_sequencer #(
    .N_DOMAINS(N),
    .CNT_W(8),
    .HOLD_DEFAULT(16),
    .GAP_DEFAULT(4)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_assert  (req_assert),
    .req_mask    (req_mask),
    .cfg_hold    (cfg_hold),
    .cfg_gap     (cfg_gap),
    .domain_reset(domain_reset),
    .busy        (busy),
    .done        (done)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s at edge %0d: got %0h expected %0h", tag, e, got, exp);
    end
  endtask

  // Value after edge 'at': k-th set bit (ascending) of a release clears k*(G+1) edges after acceptance.
  function automatic logic [N-1:0] exp_dom(input int at);
    logic [N-1:0] d;
    int k;
    d = m_base;
    k = 0;
    if (m_have && (m_mask != '0) && (at >= m_t)) begin
      if (m_op) begin
        d = m_base | m_mask;
      end else begin
        for (int b = 0; b < N; b++) begin
          if (m_mask[b]) begin
            if (at >= m_t + k * (m_g + 1)) d[b] = 1'b0;
            k++;
          end
        end
      end
    end
    return d;
  endfunction

  function automatic int exp_done_at();
    if (!m_have) return -10;
    if (m_mask == '0) return m_t;
    if (m_op) return m_t + m_h;
    return m_t + ($countones(m_mask) - 1) * (m_g + 1) + 1;
  endfunction

  task automatic step(input logic v, input logic a, input logic [N-1:0] m,
                      input logic [7:0] h, input logic [7:0] g, input logic r);
    bit ready_before;
    int dn;
    bit exp_busy;
    req_valid  = v;
    req_assert = a;
    req_mask   = m;
    cfg_hold   = h;
    cfg_gap    = g;
    reset      = r;
    ready_before = (e > exp_done_at());
    @(posedge clock);
    e++;
    if (r) begin
      m_have = 1'b0;
      m_base = '1;
    end else if (v && ready_before) begin
      m_base = exp_dom(e - 1);
      m_have = 1'b1;
      m_t    = e;
      m_op   = a;
      m_mask = m;
      m_h    = (h == 8'd0) ? 16 : int'(h);
      m_g    = (g == 8'd0) ? 4 : int'(g);
    end
    @(negedge clock);
    dn = exp_done_at();
    exp_busy = m_have && (e >= m_t) && (e <= dn);
    check_eq("domain_reset", 32'(domain_reset), 32'(exp_dom(e)));
    check_eq("done", 32'(done), 32'(m_have && (e == dn)));
    check_eq("busy", 32'(busy), 32'(exp_busy));
    check_eq("req_ready", 32'(req_ready), 32'(!exp_busy));
  endtask

  task automatic idle(input int n);
    repeat (n) step(1'b0, 1'b0, '0, '0, '0, 1'b0);
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(2);

    // release with default gap
    step(1'b1, 1'b0, 4'b1011, 8'd0, 8'd0, 1'b0);
    idle(14);
    step(1'b1, 1'b0, 4'b0100, 8'd0, 8'd1, 1'b0);
    idle(4);

    // assert with hold 3 from all-released
    step(1'b1, 1'b1, 4'b0110, 8'd3, 8'd0, 1'b0);
    idle(6);

    // empty mask
    step(1'b1, 1'b0, 4'b0000, 8'd0, 8'd0, 1'b0);
    idle(3);

    // valid held high through a busy release; later inputs vary each cycle
    step(1'b1, 1'b1, 4'b1111, 8'd1, 8'd0, 1'b0);
    idle(3);
    step(1'b1, 1'b0, 4'b1111, 8'd0, 8'd1, 1'b0);
    for (int i = 0; i < 20; i++) begin
      step(1'b1, 1'($urandom), 4'($urandom), 8'($urandom_range(0, 4)), 8'($urandom_range(0, 3)), 1'b0);
    end
    idle(20);

    // reset one cycle after the second release
    step(1'b1, 1'b1, 4'b1111, 8'd2, 8'd0, 1'b0);
    idle(4);
    step(1'b1, 1'b0, 4'b1111, 8'd0, 8'd2, 1'b0);
    idle(3);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1);
    idle(4);

    // maximum gap
    step(1'b1, 1'b0, 4'b0011, 8'd0, 8'd255, 1'b0);
    idle(262);

    for (int i = 0; i < 1500; i++) begin
      step($urandom_range(0, 2) == 0, 1'($urandom), 4'($urandom),
           8'($urandom_range(0, 6)), 8'($urandom_range(0, 5)),
           $urandom_range(0, 79) == 0);
    end
    idle(40);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
